// File: rtl/mul_div_unit_if.sv
// Handshake and result bus between the EX stage and the multiply/divide engine.
// The EX stage drives through the master modport; the engine uses the slave modport.
interface mul_div_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic                  op_div;
    logic                  op_signed;
    logic                  cancel;
    logic [DATA_WIDTH-1:0] operand_1;
    logic [DATA_WIDTH-1:0] operand_2;
    logic                  stall_request;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] hi_out;
    logic [DATA_WIDTH-1:0] lo_out;

    modport master (
        output start, op_div, op_signed, cancel, operand_1, operand_2,
        input  stall_request, busy, done, hi_out, lo_out
    );

    modport slave (
        input  start, op_div, op_signed, cancel, operand_1, operand_2,
        output stall_request, busy, done, hi_out, lo_out
    );
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine sitting beside the EX-stage ALU.
// Works on operand magnitudes and applies the sign correction in FIX.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; operands latched on acceptance
// MUL    | magnitude product formed over MUL_CYCLES cycles
// DIV    | restoring divide, one quotient bit per cycle
// FIX    | sign correction, HI/LO registered
// DONE   | one-cycle result-valid pulse; start ignored
module mul_div_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int MUL_CYCLES = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    mul_div_unit_if.slave io_md
);
    localparam int W       = DATA_WIDTH;
    localparam int CNT_MAX = (DATA_WIDTH > MUL_CYCLES) ? DATA_WIDTH : MUL_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            w_accept;
    logic            w_stall;

    logic [CNT_W-1:0] r_cnt;
    logic [W-1:0]     r_mag_a;
    logic [W-1:0]     r_mag_b;
    logic [2*W-1:0]   r_acc;       // product, or {remainder, quotient} while dividing
    logic             r_is_div;
    logic             r_neg_res;
    logic             r_neg_rem;
    logic [W-1:0]     r_hi;
    logic [W-1:0]     r_lo;

    logic             w_div_zero;
    logic [W-1:0]     w_mag_1;
    logic [W-1:0]     w_mag_2;
    logic [2*W-1:0]   w_prod;
    logic [W:0]       w_rem_sh;
    logic             w_ge;
    logic [W-1:0]     w_rem_sub;
    logic [W-1:0]     w_rem_next;
    logic [2*W-1:0]   w_acc_div;
    logic [2*W-1:0]   w_prod_fix;
    logic [W-1:0]     w_quot_fix;
    logic [W-1:0]     w_rem_fix;

    // Operand magnitudes; divide-by-zero is detected on the raw divisor.
    assign w_div_zero = io_md.op_div && (io_md.operand_2 == '0);
    assign w_mag_1    = (io_md.op_signed && io_md.operand_1[W-1]) ? -io_md.operand_1 : io_md.operand_1;
    assign w_mag_2    = (io_md.op_signed && io_md.operand_2[W-1]) ? -io_md.operand_2 : io_md.operand_2;

    // Multiplier array, recomputed every MUL cycle to model a retimed array.
    assign w_prod = {{W{1'b0}}, r_mag_a} * {{W{1'b0}}, r_mag_b};

    // Restoring divide step. The shifted remainder needs W+1 bits for the
    // compare; when the subtraction is taken the result is below the divisor,
    // so W-bit modular arithmetic is exact.
    assign w_rem_sh   = r_acc[2*W-1:W-1];
    assign w_ge       = (w_rem_sh >= {1'b0, r_mag_b});
    assign w_rem_sub  = w_rem_sh[W-1:0] - r_mag_b;
    assign w_rem_next = w_ge ? w_rem_sub : w_rem_sh[W-1:0];
    assign w_acc_div  = {w_rem_next, r_acc[W-2:0], w_ge};

    // Sign correction. The quotient follows the operand signs, the remainder
    // follows the dividend, which gives truncation toward zero.
    assign w_prod_fix = r_neg_res ? -r_acc : r_acc;
    assign w_quot_fix = r_neg_res ? -r_acc[W-1:0] : r_acc[W-1:0];
    assign w_rem_fix  = r_neg_rem ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, acceptance and stall decode; cancel drops stall immediately.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_stall      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (io_md.start && !io_md.cancel) begin
                    w_accept = 1'b1;
                    w_stall  = 1'b1;
                    if (io_md.op_div) begin
                        w_state_next = w_div_zero ? S_DONE : S_DIV;
                    end else begin
                        w_state_next = S_MUL;
                    end
                end
            end
            S_MUL: begin
                if (io_md.cancel) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_stall = 1'b1;
                    if (r_cnt == MUL_LAST) begin
                        w_state_next = S_FIX;
                    end
                end
            end
            S_DIV: begin
                if (io_md.cancel) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_stall = 1'b1;
                    if (r_cnt == DIV_LAST) begin
                        w_state_next = S_FIX;
                    end
                end
            end
            S_FIX: begin
                if (io_md.cancel) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_stall      = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, iteration and result registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_cnt     <= '0;
            r_mag_a   <= '0;
            r_mag_b   <= '0;
            r_acc     <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt     <= '0;
                        r_is_div  <= io_md.op_div;
                        r_mag_a   <= w_mag_1;
                        r_mag_b   <= w_mag_2;
                        r_acc     <= {{W{1'b0}}, w_mag_1};
                        r_neg_res <= io_md.op_signed && (io_md.operand_1[W-1] ^ io_md.operand_2[W-1]);
                        r_neg_rem <= io_md.op_signed && io_md.operand_1[W-1];
                        if (w_div_zero) begin
                            r_hi <= io_md.operand_1;
                            r_lo <= '1;
                        end
                    end
                end
                S_MUL: begin
                    r_acc <= w_prod;
                    r_cnt <= r_cnt + 1'b1;
                end
                S_DIV: begin
                    r_acc <= w_acc_div;
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    if (!io_md.cancel) begin
                        if (r_is_div) begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quot_fix;
                        end else begin
                            r_hi <= w_prod_fix[2*W-1:W];
                            r_lo <= w_prod_fix[W-1:0];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign io_md.stall_request = w_stall;
    assign io_md.busy          = (r_state != S_IDLE);
    assign io_md.done          = (r_state == S_DONE);
    assign io_md.hi_out        = r_hi;
    assign io_md.lo_out        = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus random
// operations compared against a plain-arithmetic reference model.
module tb_mul_div_unit;
    localparam int W  = 32;
    localparam int MC = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mul_div_unit_if #(.DATA_WIDTH(W)) md_if ();

    mul_div_unit #(
        .DATA_WIDTH(W),
        .MUL_CYCLES(MC)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .io_md (md_if.slave)
    );

    // Reference: 64-bit integer arithmetic; SV '/' and '%' truncate toward zero
    // and give the remainder the dividend's sign.
    function automatic void model(input bit div, input bit sgn, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] hi,
                                  output logic [W-1:0] lo, output int lat);
        longint          sa, sb, sp;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        if (!div) begin
            lat = MC + 2;
            if (sgn) begin
                sp = sa * sb;
                hi = sp[63:32];
                lo = sp[31:0];
            end else begin
                up = ua * ub;
                hi = up[63:32];
                lo = up[31:0];
            end
        end else if (b == 0) begin
            lat = 1;
            hi  = a;
            lo  = '1;
        end else begin
            lat = W + 2;
            if (sgn) begin
                sp = sa / sb;
                lo = sp[31:0];
                sp = sa % sb;
                hi = sp[31:0];
            end else begin
                up = ua / ub;
                lo = up[31:0];
                up = ua % ub;
                hi = up[31:0];
            end
        end
    endfunction

    // Issue one operation and wait for done. lat counts negedges from the start
    // cycle to the done cycle (-1 on timeout); stalls counts cycles with stall high.
    task automatic run_op(input bit div, input bit sgn, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit hold, output int lat,
                          output int stalls, output logic [W-1:0] hi, output logic [W-1:0] lo);
        lat    = -1;
        stalls = 0;
        hi     = '0;
        lo     = '0;
        @(negedge clk);
        md_if.start     = 1'b1;
        md_if.op_div    = div;
        md_if.op_signed = sgn;
        md_if.operand_1 = a;
        md_if.operand_2 = b;
        #1;
        if (md_if.stall_request) stalls++;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            md_if.start     = hold;
            md_if.operand_1 = $urandom;
            md_if.operand_2 = $urandom;
            #1;
            if (md_if.done) begin
                lat = c;
                hi  = md_if.hi_out;
                lo  = md_if.lo_out;
                break;
            end
            if (md_if.stall_request) stalls++;
        end
    endtask

    task automatic test_reset();
        md_if.start     = 1'b1;
        md_if.cancel    = 1'b0;
        md_if.op_div    = 1'b0;
        md_if.op_signed = 1'b0;
        md_if.operand_1 = 32'd9;
        md_if.operand_2 = 32'd9;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (md_if.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", md_if.busy); end
        n_checks++; if (md_if.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", md_if.done); end
        n_checks++; if (md_if.hi_out !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", md_if.hi_out); end
        n_checks++; if (md_if.lo_out !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", md_if.lo_out); end
        md_if.start = 1'b0;
        #1;
        n_checks++; if (md_if.stall_request !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", md_if.stall_request); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_mult();
        int lat, st, elat;
        logic [W-1:0] hi, lo, ehi, elo, a, b;
        bit s;
        run_op(1'b0, 1'b1, 32'hFFFFFFFD, 32'd7, 1'b0, lat, st, hi, lo);
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL mult_lat: got %0d want 4", lat); end
        n_checks++; if (st !== 4) begin n_fail++; $display("FAIL mult_stall_cycles: got %0d want 4", st); end
        n_checks++; if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
        n_checks++; if (lo !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mult_lo: got %h want ffffffeb", lo); end
        @(negedge clk); #1;
        n_checks++; if (md_if.done !== 1'b0) begin n_fail++; $display("FAIL mult_done_width: got %b want 0", md_if.done); end
        run_op(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, lat, st, hi, lo);
        n_checks++; if (hi !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
        n_checks++; if (lo !== 32'h00000001) begin n_fail++; $display("FAIL multu_lo: got %h want 00000001", lo); end
        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            model(1'b0, s, a, b, ehi, elo, elat);
            run_op(1'b0, s, a, b, 1'b0, lat, st, hi, lo);
            n_checks++; if (lat !== elat) begin n_fail++; $display("FAIL rand_mul_lat: got %0d want %0d", lat, elat); end
            n_checks++; if (hi !== ehi) begin n_fail++; $display("FAIL rand_mul_hi s=%0d %h*%h: got %h want %h", s, a, b, hi, ehi); end
            n_checks++; if (lo !== elo) begin n_fail++; $display("FAIL rand_mul_lo s=%0d %h*%h: got %h want %h", s, a, b, lo, elo); end
        end
    endtask

    task automatic test_div();
        int lat, st, elat;
        logic [W-1:0] hi, lo, ehi, elo, a, b;
        bit s;
        run_op(1'b1, 1'b0, 32'd100, 32'd7, 1'b0, lat, st, hi, lo);
        n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL divu_lat: got %0d want 34", lat); end
        n_checks++; if (st !== 34) begin n_fail++; $display("FAIL divu_stall_cycles: got %0d want 34", st); end
        n_checks++; if (lo !== 32'd14) begin n_fail++; $display("FAIL divu_lo: got %h want 0000000e", lo); end
        n_checks++; if (hi !== 32'd2) begin n_fail++; $display("FAIL divu_hi: got %h want 00000002", hi); end
        run_op(1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, 1'b0, lat, st, hi, lo);
        n_checks++; if (lo !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_neg_lo: got %h want fffffffd", lo); end
        n_checks++; if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_neg_hi: got %h want ffffffff", hi); end
        run_op(1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0, lat, st, hi, lo);
        n_checks++; if (lo !== 32'h80000000) begin n_fail++; $display("FAIL div_ovf_lo: got %h want 80000000", lo); end
        n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL div_ovf_hi: got %h want 00000000", hi); end
        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : 32'($urandom);
            if ($urandom_range(0, 3) == 0) b = -b;
            s = 1'($urandom_range(0, 1));
            model(1'b1, s, a, b, ehi, elo, elat);
            run_op(1'b1, s, a, b, 1'b0, lat, st, hi, lo);
            n_checks++; if (lat !== elat) begin n_fail++; $display("FAIL rand_div_lat: got %0d want %0d", lat, elat); end
            n_checks++; if (lo !== elo) begin n_fail++; $display("FAIL rand_div_lo s=%0d %h/%h: got %h want %h", s, a, b, lo, elo); end
            n_checks++; if (hi !== ehi) begin n_fail++; $display("FAIL rand_div_hi s=%0d %h/%h: got %h want %h", s, a, b, hi, ehi); end
        end
    endtask

    task automatic test_div_zero();
        int lat, st;
        logic [W-1:0] hi, lo;
        run_op(1'b1, 1'b1, 32'd5, 32'd0, 1'b0, lat, st, hi, lo);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL divz_lat: got %0d want 1", lat); end
        n_checks++; if (st !== 1) begin n_fail++; $display("FAIL divz_stall_cycles: got %0d want 1", st); end
        n_checks++; if (lo !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL divz_lo: got %h want ffffffff", lo); end
        n_checks++; if (hi !== 32'd5) begin n_fail++; $display("FAIL divz_hi: got %h want 00000005", hi); end
        run_op(1'b1, 1'b1, 32'hFFFFFFF7, 32'd0, 1'b0, lat, st, hi, lo);
        n_checks++; if (hi !== 32'hFFFFFFF7) begin n_fail++; $display("FAIL divz_neg_hi: got %h want fffffff7", hi); end
    endtask

    task automatic test_cancel();
        int lat, st, dones;
        logic [W-1:0] hi, lo;
        run_op(1'b0, 1'b0, 32'h1234, 32'h10, 1'b0, lat, st, hi, lo);
        n_checks++; if (lo !== 32'h12340) begin n_fail++; $display("FAIL cancel_pre_lo: got %h want 00012340", lo); end
        @(negedge clk);
        md_if.start     = 1'b1;
        md_if.op_div    = 1'b1;
        md_if.op_signed = 1'b0;
        md_if.operand_1 = 32'd1000;
        md_if.operand_2 = 32'd3;
        repeat (9) begin
            @(negedge clk);
            md_if.start = 1'b0;
        end
        @(negedge clk);
        md_if.cancel = 1'b1;
        #1;
        n_checks++; if (md_if.stall_request !== 1'b0) begin n_fail++; $display("FAIL cancel_stall_comb: got %b want 0", md_if.stall_request); end
        n_checks++; if (md_if.busy !== 1'b1) begin n_fail++; $display("FAIL cancel_busy_before: got %b want 1", md_if.busy); end
        @(negedge clk);
        md_if.cancel = 1'b0;
        #1;
        n_checks++; if (md_if.busy !== 1'b0) begin n_fail++; $display("FAIL cancel_idle: got %b want 0", md_if.busy); end
        n_checks++; if (md_if.hi_out !== 32'h0 || md_if.lo_out !== 32'h12340) begin
            n_fail++; $display("FAIL cancel_hold: got %h_%h want 00000000_00012340", md_if.hi_out, md_if.lo_out);
        end
        dones = 0;
        repeat (40) begin
            @(negedge clk); #1;
            if (md_if.done) dones++;
        end
        n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL cancel_no_done: got %0d pulses want 0", dones); end
        // cancel while idle must block acceptance
        @(negedge clk);
        md_if.start  = 1'b1;
        md_if.cancel = 1'b1;
        #1;
        n_checks++; if (md_if.stall_request !== 1'b0) begin n_fail++; $display("FAIL idle_cancel_stall: got %b want 0", md_if.stall_request); end
        @(negedge clk);
        md_if.start  = 1'b0;
        md_if.cancel = 1'b0;
        #1;
        n_checks++; if (md_if.busy !== 1'b0) begin n_fail++; $display("FAIL idle_cancel_busy: got %b want 0", md_if.busy); end
        run_op(1'b0, 1'b0, 32'd3, 32'd4, 1'b0, lat, st, hi, lo);
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL post_cancel_lat: got %0d want 4", lat); end
        n_checks++; if (lo !== 32'd12 || hi !== 32'd0) begin n_fail++; $display("FAIL post_cancel_res: got %h_%h want 00000000_0000000c", hi, lo); end
    endtask

    task automatic test_reset_mid();
        int dones;
        @(negedge clk);
        md_if.start     = 1'b1;
        md_if.op_div    = 1'b1;
        md_if.op_signed = 1'b1;
        md_if.operand_1 = 32'hFFFF0000;
        md_if.operand_2 = 32'd77;
        repeat (5) begin
            @(negedge clk);
            md_if.start = 1'b0;
        end
        rst = 1'b0;
        @(negedge clk); #1;
        n_checks++; if (md_if.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", md_if.busy); end
        n_checks++; if (md_if.stall_request !== 1'b0) begin n_fail++; $display("FAIL rstmid_stall: got %b want 0", md_if.stall_request); end
        n_checks++; if (md_if.hi_out !== 32'h0 || md_if.lo_out !== 32'h0) begin
            n_fail++; $display("FAIL rstmid_res: got %h_%h want 00000000_00000000", md_if.hi_out, md_if.lo_out);
        end
        rst   = 1'b1;
        dones = 0;
        repeat (40) begin
            @(negedge clk); #1;
            if (md_if.done) dones++;
        end
        n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d pulses want 0", dones); end
    endtask

    task automatic test_back_to_back();
        int lat, st, dones;
        logic [W-1:0] hi, lo;
        // start held through DONE, operands scrambled mid-operation
        run_op(1'b1, 1'b0, 32'd1000, 32'd3, 1'b1, lat, st, hi, lo);
        n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL held_lat: got %0d want 34", lat); end
        n_checks++; if (lo !== 32'd333 || hi !== 32'd1) begin n_fail++; $display("FAIL held_res: got %h_%h want 00000001_0000014d", hi, lo); end
        @(negedge clk);
        md_if.start = 1'b0;
        dones = 0;
        repeat (45) begin
            @(negedge clk); #1;
            if (md_if.done) dones++;
        end
        n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL held_single_op: got %0d extra pulses want 0", dones); end
        // two operations issued with no idle gap between them
        run_op(1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, lat, st, hi, lo);
        n_checks++; if (lo !== 32'd1 || hi !== 32'd0) begin n_fail++; $display("FAIL b2b_first: got %h_%h want 00000000_00000001", hi, lo); end
        run_op(1'b1, 1'b1, 32'd9, 32'hFFFFFFFE, 1'b0, lat, st, hi, lo);
        n_checks++; if (lo !== 32'hFFFFFFFC || hi !== 32'd1) begin n_fail++; $display("FAIL b2b_second: got %h_%h want 00000001_fffffffc", hi, lo); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_cancel();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
